// File: rtl/rgb_fade_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_fade_pkg
//  Brief    : State type and next-state / direction helpers for the RGB
//             colour-wheel fader.
//  Revision : 1.0 - initial release
// ============================================================================
package rgb_fade_pkg;

    // Six ramp states, listed in wheel order. Encodings 6 and 7 are unused.
    typedef enum logic [2:0] {
        GREEN_INC = 3'd0,
        RED_DEC   = 3'd1,
        BLUE_INC  = 3'd2,
        GREEN_DEC = 3'd3,
        RED_INC   = 3'd4,
        BLUE_DEC  = 3'd5
    } fade_state_t;

    // Successor on the wheel; anything unrecognised restarts the wheel.
    function automatic fade_state_t next_state(input fade_state_t state);
        case (state)
            GREEN_INC: next_state = RED_DEC;
            RED_DEC:   next_state = BLUE_INC;
            BLUE_INC:  next_state = GREEN_DEC;
            GREEN_DEC: next_state = RED_INC;
            RED_INC:   next_state = BLUE_DEC;
            default:   next_state = GREEN_INC;
        endcase
    endfunction

    // True for the states whose ramping channel counts upward.
    function automatic logic is_inc(input fade_state_t state);
        is_inc = (state == GREEN_INC) || (state == BLUE_INC) || (state == RED_INC);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_fade_top_pwm_channel.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_channel
//  Brief    : One active-low PWM output. The channel is lit while the shared
//             counter is below the duty; the pin is registered.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_channel #(
    parameter int   PWM_INTERVAL = 1000,
    parameter logic RESET_PIN    = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [$clog2(PWM_INTERVAL+1)-1:0] pwm_cnt,
    input  logic [$clog2(PWM_INTERVAL+1)-1:0] duty,
    output logic                              o_led_n
);

    logic r_led_n;

    // Register the inverted compare so the pin is glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led_n <= RESET_PIN;
        end else begin
            r_led_n <= ~(pwm_cnt < duty);
        end
    end

    assign o_led_n = r_led_n;

endmodule
`default_nettype wire

// File: rtl/rgb_fade_top.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_fade_top
//  Brief    : RGB colour-wheel fader. A six-state ramp machine sets three
//             duties that drive phase-aligned active-low PWM pins.
//  Revision : 1.0 - initial release
// ============================================================================
module rgb_fade_top
    import rgb_fade_pkg::*;
#(
    parameter int PWM_INTERVAL = 1000,
    parameter int STEP_CYCLES  = 2000
) (
    input  logic clk,
    input  logic rst,
    output logic RGB_R,
    output logic RGB_G,
    output logic RGB_B
);

    localparam int                  c_cnt_w    = $clog2(PWM_INTERVAL + 1);
    localparam int                  c_step_w   = $clog2(STEP_CYCLES + 1);
    localparam logic [c_cnt_w-1:0]  c_full     = c_cnt_w'(PWM_INTERVAL);
    localparam logic [c_cnt_w-1:0]  c_pwm_last = c_cnt_w'(PWM_INTERVAL - 1);
    localparam logic [c_cnt_w-1:0]  c_one      = c_cnt_w'(1);
    localparam logic [c_step_w-1:0] c_step_last = c_step_w'(STEP_CYCLES - 1);
    localparam logic [c_step_w-1:0] c_step_one  = c_step_w'(1);

    fade_state_t          current_state;
    logic [c_cnt_w-1:0]   pwm_value;
    logic [c_step_w-1:0]  r_step_cnt;
    logic [c_cnt_w-1:0]   r_pwm_cnt;
    logic                 w_tick;
    logic [c_cnt_w-1:0]   w_duty_r;
    logic [c_cnt_w-1:0]   w_duty_g;
    logic [c_cnt_w-1:0]   w_duty_b;

    assign w_tick = (r_step_cnt == c_step_last);

    // Step prescaler: one duty step every STEP_CYCLES clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step_cnt <= '0;
        end else if (r_step_cnt == c_step_last) begin
            r_step_cnt <= '0;
        end else begin
            r_step_cnt <= r_step_cnt + c_step_one;
        end
    end

    // Shared PWM period counter so all three channels stay phase-aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= '0;
        end else if (r_pwm_cnt == c_pwm_last) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + c_one;
        end
    end

    // Ramp machine: step the duty on each tick, advance once it hits the end
    // stop. The end-stop tick holds pwm_value, giving I+1 ticks per state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            current_state <= GREEN_INC;
            pwm_value     <= '0;
        end else begin
            case (current_state)
                GREEN_INC, RED_DEC, BLUE_INC, GREEN_DEC, RED_INC, BLUE_DEC: begin
                    if (w_tick) begin
                        if (is_inc(current_state)) begin
                            if (pwm_value < c_full) begin
                                pwm_value <= pwm_value + c_one;
                            end else begin
                                current_state <= next_state(current_state);
                            end
                        end else begin
                            if (pwm_value > '0) begin
                                pwm_value <= pwm_value - c_one;
                            end else begin
                                current_state <= next_state(current_state);
                            end
                        end
                    end
                end
                default: begin
                    current_state <= GREEN_INC;
                    pwm_value     <= '0;
                end
            endcase
        end
    end

    // Map the state to per-channel duties: one ramping, two held.
    always_comb begin
        w_duty_r = '0;
        w_duty_g = '0;
        w_duty_b = '0;
        case (current_state)
            GREEN_INC: begin w_duty_r = c_full;    w_duty_g = pwm_value; end
            RED_DEC:   begin w_duty_r = pwm_value; w_duty_g = c_full;    end
            BLUE_INC:  begin w_duty_g = c_full;    w_duty_b = pwm_value; end
            GREEN_DEC: begin w_duty_g = pwm_value; w_duty_b = c_full;    end
            RED_INC:   begin w_duty_r = pwm_value; w_duty_b = c_full;    end
            BLUE_DEC:  begin w_duty_r = c_full;    w_duty_b = pwm_value; end
            default:   begin w_duty_r = '0;        w_duty_g = '0;        end
        endcase
    end

    // Red resets lit because GREEN_INC holds red at full scale.
    pwm_channel #(.PWM_INTERVAL(PWM_INTERVAL), .RESET_PIN(1'b0)) u_pwm_r (
        .clk     (clk),
        .rst     (rst),
        .pwm_cnt (r_pwm_cnt),
        .duty    (w_duty_r),
        .o_led_n (RGB_R)
    );

    pwm_channel #(.PWM_INTERVAL(PWM_INTERVAL), .RESET_PIN(1'b1)) u_pwm_g (
        .clk     (clk),
        .rst     (rst),
        .pwm_cnt (r_pwm_cnt),
        .duty    (w_duty_g),
        .o_led_n (RGB_G)
    );

    pwm_channel #(.PWM_INTERVAL(PWM_INTERVAL), .RESET_PIN(1'b1)) u_pwm_b (
        .clk     (clk),
        .rst     (rst),
        .pwm_cnt (r_pwm_cnt),
        .duty    (w_duty_b),
        .o_led_n (RGB_B)
    );

endmodule
`default_nettype wire

// File: tb/tb_rgb_fade_top.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rgb_fade_top
//  Brief    : Directed bench for rgb_fade_top: reset, ramp timing, a full
//             colour wheel with held-pin checks, PWM duty and mid-ramp reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_fade_top;
    import rgb_fade_pkg::*;

    logic clk;
    logic rst;
    logic rst2;
    logic pin_r, pin_g, pin_b;
    logic pin_r2, pin_g2, pin_b2;

    int n_vec;
    int n_bad;

    rgb_fade_top #(.PWM_INTERVAL(10), .STEP_CYCLES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .RGB_R (pin_r),
        .RGB_G (pin_g),
        .RGB_B (pin_b)
    );

    // Slow-stepping instance used to hold one duty long enough to measure it.
    rgb_fade_top #(.PWM_INTERVAL(10), .STEP_CYCLES(100)) dut_hold (
        .clk   (clk),
        .rst   (rst2),
        .RGB_R (pin_r2),
        .RGB_G (pin_g2),
        .RGB_B (pin_b2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wheel order and hand-derived held pins per state (2 = ramping channel).
    fade_state_t order [6];
    int          inc_st [6];
    int          exp_r [6];
    int          exp_g [6];
    int          exp_b [6];

    initial begin
        int nl_r, nl_g, nl_b;
        fade_state_t cur, nxt;

        order  = '{GREEN_INC, RED_DEC, BLUE_INC, GREEN_DEC, RED_INC, BLUE_DEC};
        inc_st = '{1, 0, 1, 0, 1, 0};
        exp_r  = '{0, 2, 1, 1, 2, 0};
        exp_g  = '{2, 0, 0, 2, 1, 1};
        exp_b  = '{1, 1, 2, 0, 0, 2};
        n_vec = 0;
        n_bad = 0;
        rst  = 1'b1;
        rst2 = 1'b1;

        // Reset state
        step(3);
        chk("rst_state", 32'(dut.current_state), 32'(GREEN_INC));
        chk("rst_pwm",   32'(dut.pwm_value), 0);
        chk("rst_R", 32'(pin_r), 0);
        chk("rst_G", 32'(pin_g), 1);
        chk("rst_B", 32'(pin_b), 1);

        // Ramp timing after release
        @(negedge clk);
        rst = 1'b0;
        step(3);
        chk("ramp_c3_pwm", 32'(dut.pwm_value), 0);
        step(1);
        chk("ramp_c4_pwm", 32'(dut.pwm_value), 1);
        step(36);
        chk("ramp_c40_pwm", 32'(dut.pwm_value), 10);
        chk("ramp_c40_state", 32'(dut.current_state), 32'(GREEN_INC));
        step(3);
        chk("ramp_c43_state", 32'(dut.current_state), 32'(GREEN_INC));
        step(1);
        chk("ramp_c44_state", 32'(dut.current_state), 32'(RED_DEC));
        chk("ramp_c44_pwm", 32'(dut.pwm_value), 10);

        // Remainder of the wheel: each state lasts exactly 44 clocks
        for (int k = 1; k < 6; k++) begin
            cur = order[k];
            nxt = order[(k + 1) % 6];
            for (int j = 1; j <= 44; j++) begin
                step(1);
                if (j < 44) begin
                    chk("wheel_state", 32'(dut.current_state), 32'(cur));
                    if (exp_r[k] != 2) chk("wheel_R", 32'(pin_r), 32'(exp_r[k]));
                    if (exp_g[k] != 2) chk("wheel_G", 32'(pin_g), 32'(exp_g[k]));
                    if (exp_b[k] != 2) chk("wheel_B", 32'(pin_b), 32'(exp_b[k]));
                    if (j == 4) chk("wheel_first_step", 32'(dut.pwm_value),
                                    (inc_st[k] != 0) ? 32'd1 : 32'd9);
                end else begin
                    chk("wheel_next_state", 32'(dut.current_state), 32'(nxt));
                    chk("wheel_entry_pwm", 32'(dut.pwm_value),
                        (inc_st[k] != 0) ? 32'd10 : 32'd0);
                end
            end
        end

        // Reach GREEN_DEC with pwm_value 5, then reset asynchronously
        step(152);
        chk("mid_state", 32'(dut.current_state), 32'(GREEN_DEC));
        chk("mid_pwm", 32'(dut.pwm_value), 5);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_state", 32'(dut.current_state), 32'(GREEN_INC));
        chk("async_pwm", 32'(dut.pwm_value), 0);
        chk("async_R", 32'(pin_r), 0);
        chk("async_G", 32'(pin_g), 1);
        chk("async_B", 32'(pin_b), 1);
        step(2);
        @(negedge clk);
        rst = 1'b0;
        step(3);
        chk("restart_c3_pwm", 32'(dut.pwm_value), 0);
        chk("restart_c3_state", 32'(dut.current_state), 32'(GREEN_INC));
        step(1);
        chk("restart_c4_pwm", 32'(dut.pwm_value), 1);

        // PWM duty: hold GREEN_INC at pwm_value 3 and count low pins per period
        @(negedge clk);
        rst2 = 1'b0;
        step(310);
        chk("hold_state", 32'(dut_hold.current_state), 32'(GREEN_INC));
        chk("hold_pwm", 32'(dut_hold.pwm_value), 3);
        nl_r = 0;
        nl_g = 0;
        nl_b = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (pin_r2 == 1'b0) nl_r++;
            if (pin_g2 == 1'b0) nl_g++;
            if (pin_b2 == 1'b0) nl_b++;
        end
        chk("duty_R_lows", 32'(nl_r), 10);
        chk("duty_G_lows", 32'(nl_g), 3);
        chk("duty_B_lows", 32'(nl_b), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
